// File: rtl/sweep_pkg.sv
// ============================================================================
// Package : sweep_pkg
// Brief   : Shared encodings and defaults for the sweep sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package sweep_pkg;

  localparam logic [1:0]  C_MODE_NONE     = 2'b00;
  localparam logic [1:0]  C_MODE_LINEAR   = 2'b01;
  localparam logic [1:0]  C_MODE_SINE     = 2'b10;

  localparam int          C_DEPTH         = 8;
  localparam int          C_CYCLES_PER_MS = 100000;
  localparam logic [19:0] C_RESET_FREQ    = 20'd100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ms_prescaler.sv
// ============================================================================
// Module : ms_prescaler
// Brief  : Free-running millisecond tick generator with synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_prescaler #(
  parameter int CYCLES_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CYCLES_PER_MS - 1);

  logic [CNT_W-1:0] r_count;

  // tick fires on the last cycle of each millisecond window
  assign tick = !clear && (r_count == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || (r_count == C_LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sweep_sequencer.sv
// ============================================================================
// Module : sweep_sequencer
// Brief  : Steps through a small program of frequency/mode/dwell entries.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int CYCLES_PER_MS = C_CYCLES_PER_MS,
  parameter int DEPTH         = C_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [19:0] wr_freq,
  input  logic [1:0]  wr_mode,
  input  logic [15:0] wr_dwell,
  input  logic [3:0]  num_steps,
  input  logic        loop_en,
  input  logic        start,
  input  logic        stop,
  output logic [19:0] base_freq,
  output logic [1:0]  sweep_mode,
  output logic [2:0]  step_idx,
  output logic        busy,
  output logic        step_strobe,
  output logic        done,
  output logic        err
);

  state_t      r_state, w_state_next;
  logic [2:0]  r_cur_idx, w_cur_idx_next;
  logic [3:0]  r_num_steps, w_num_steps_next;
  logic [15:0] r_dwell_cnt, w_dwell_cnt_next;
  logic [19:0] r_base_freq, w_base_freq_next;
  logic [1:0]  r_sweep_mode, w_sweep_mode_next;
  logic [2:0]  r_step_idx, w_step_idx_next;
  logic        r_step_strobe, w_step_strobe_next;
  logic        r_done, w_done_next;
  logic        r_err, w_err_next;

  logic [19:0] r_mem_freq  [DEPTH];
  logic [1:0]  r_mem_mode  [DEPTH];
  logic [15:0] r_mem_dwell [DEPTH];

  logic w_tick;
  logic w_num_ok;
  logic w_last;

  ms_prescaler #(
    .CYCLES_PER_MS (CYCLES_PER_MS)
  ) u_ms_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (r_state != ST_DWELL),
    .tick  (w_tick)
  );

  assign w_num_ok = (num_steps != 4'd0) && (int'(num_steps) <= DEPTH);
  assign w_last   = ({1'b0, r_cur_idx} == (r_num_steps - 4'd1));

  // Program storage: writes are only accepted while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_freq[i]  <= '0;
        r_mem_mode[i]  <= '0;
        r_mem_dwell[i] <= '0;
      end
    end else if (wr_en && (r_state == ST_IDLE)) begin
      r_mem_freq[wr_addr]  <= wr_freq;
      r_mem_mode[wr_addr]  <= wr_mode;
      r_mem_dwell[wr_addr] <= wr_dwell;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cur_idx     <= '0;
      r_num_steps   <= '0;
      r_dwell_cnt   <= '0;
      r_base_freq   <= C_RESET_FREQ;
      r_sweep_mode  <= C_MODE_NONE;
      r_step_idx    <= '0;
      r_step_strobe <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cur_idx     <= w_cur_idx_next;
      r_num_steps   <= w_num_steps_next;
      r_dwell_cnt   <= w_dwell_cnt_next;
      r_base_freq   <= w_base_freq_next;
      r_sweep_mode  <= w_sweep_mode_next;
      r_step_idx    <= w_step_idx_next;
      r_step_strobe <= w_step_strobe_next;
      r_done        <= w_done_next;
      r_err         <= w_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cur_idx_next     = r_cur_idx;
    w_num_steps_next   = r_num_steps;
    w_dwell_cnt_next   = r_dwell_cnt;
    w_base_freq_next   = r_base_freq;
    w_sweep_mode_next  = r_sweep_mode;
    w_step_idx_next    = r_step_idx;
    w_step_strobe_next = 1'b0;
    w_done_next        = 1'b0;
    w_err_next         = wr_en && (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (w_num_ok) begin
            w_num_steps_next = num_steps;
            w_cur_idx_next   = 3'd0;
            w_state_next     = ST_LOAD;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else begin
          w_base_freq_next   = r_mem_freq[r_cur_idx];
          w_sweep_mode_next  = r_mem_mode[r_cur_idx];
          w_step_idx_next    = r_cur_idx;
          w_step_strobe_next = 1'b1;
          // a zero dwell is treated as one millisecond
          w_dwell_cnt_next   = (r_mem_dwell[r_cur_idx] == 16'd0) ? 16'd1
                                                                 : r_mem_dwell[r_cur_idx];
          w_state_next       = ST_DWELL;
        end
      end

      ST_DWELL: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_tick) begin
          if (r_dwell_cnt <= 16'd1) begin
            w_dwell_cnt_next = 16'd0;
            if (!w_last) begin
              w_cur_idx_next = r_cur_idx + 3'd1;
              w_state_next   = ST_LOAD;
            end else if (loop_en) begin
              w_cur_idx_next = 3'd0;
              w_state_next   = ST_LOAD;
            end else begin
              w_done_next  = 1'b1;
              w_state_next = ST_IDLE;
            end
          end else begin
            w_dwell_cnt_next = r_dwell_cnt - 16'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign base_freq   = r_base_freq;
  assign sweep_mode  = r_sweep_mode;
  assign step_idx    = r_step_idx;
  assign busy        = (r_state != ST_IDLE);
  assign step_strobe = r_step_strobe;
  assign done        = r_done;
  assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
// ============================================================================
// Module : tb_sweep_sequencer
// Brief  : Directed self-checking bench for sweep_sequencer (1 ms = 10 cycles).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sweep_sequencer;

  localparam int CPM = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [19:0] wr_freq = '0;
  logic [1:0]  wr_mode = '0;
  logic [15:0] wr_dwell = '0;
  logic [3:0]  num_steps = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [19:0] base_freq;
  logic [1:0]  sweep_mode;
  logic [2:0]  step_idx;
  logic        busy, step_strobe, done, err;

  sweep_sequencer #(
    .CYCLES_PER_MS (CPM),
    .DEPTH         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_freq     (wr_freq),
    .wr_mode     (wr_mode),
    .wr_dwell    (wr_dwell),
    .num_steps   (num_steps),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .base_freq   (base_freq),
    .sweep_mode  (sweep_mode),
    .step_idx    (step_idx),
    .busy        (busy),
    .step_strobe (step_strobe),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc = 0;
  int          strobe_t [$];
  logic [19:0] strobe_f [$];
  logic [1:0]  strobe_m [$];
  logic [2:0]  strobe_i [$];
  int          done_cnt = 0;
  int          done_t = 0;
  int          err_cnt = 0;

  // Event log sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (step_strobe) begin
      strobe_t.push_back(cyc);
      strobe_f.push_back(base_freq);
      strobe_m.push_back(sweep_mode);
      strobe_i.push_back(step_idx);
    end
    if (done) begin
      done_cnt++;
      done_t = cyc;
    end
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    strobe_t.delete();
    strobe_f.delete();
    strobe_m.delete();
    strobe_i.delete();
    done_cnt = 0;
    done_t   = 0;
    err_cnt  = 0;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [19:0] f,
                             input logic [1:0] m, input logic [15:0] d);
    wr_addr  = a;
    wr_freq  = f;
    wr_mode  = m;
    wr_dwell = d;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] n);
    num_steps = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check(tag, busy, 0);
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k = 0;
    while (strobe_t.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (strobe_t.size() < n) check(tag, strobe_t.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_freq"}, base_freq, 100000);
    check({tag, "_mode"}, sweep_mode, 0);
    check({tag, "_idx"}, step_idx, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_strobe"}, step_strobe, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Basic three-entry run
    write_entry(3'd0, 20'd10000,  2'b01, 16'd2);
    write_entry(3'd1, 20'd50000,  2'b10, 16'd1);
    write_entry(3'd2, 20'd200000, 2'b00, 16'd3);
    clear_log();
    loop_en = 1'b0;
    pulse_start(4'd3);
    check("run_busy", busy, 1);
    wait_idle(200, "run_timeout");
    check("run_nstrobe", strobe_t.size(), 3);
    if (strobe_t.size() >= 3) begin
      check("run_gap0", strobe_t[1] - strobe_t[0], 21);
      check("run_gap1", strobe_t[2] - strobe_t[1], 11);
      // last entry dwells 30 cycles before done
      check("run_last_dwell", done_t - strobe_t[2], 30);
      check("run_f0", strobe_f[0], 10000);
      check("run_f1", strobe_f[1], 50000);
      check("run_f2", strobe_f[2], 200000);
      check("run_m0", strobe_m[0], 1);
      check("run_m1", strobe_m[1], 2);
      check("run_m2", strobe_m[2], 0);
      check("run_idx", {strobe_i[0], strobe_i[1], strobe_i[2]}, {3'd0, 3'd1, 3'd2});
    end
    check("run_done_cnt", done_cnt, 1);
    check("run_busy_end", busy, 0);
    check("run_hold_freq", base_freq, 200000);
    check("run_hold_idx", step_idx, 2);

    // Looping
    clear_log();
    loop_en = 1'b1;
    pulse_start(4'd3);
    wait_strobes(5, 300, "loop_timeout");
    if (strobe_t.size() >= 5) begin
      check("loop_idx", {strobe_i[0], strobe_i[1], strobe_i[2], strobe_i[3], strobe_i[4]},
            {3'd0, 3'd1, 3'd2, 3'd0, 3'd1});
      check("loop_wrap_gap", strobe_t[3] - strobe_t[2], 31);
      check("loop_f3", strobe_f[3], 10000);
    end
    check("loop_no_done", done_cnt, 0);
    pulse_stop();
    check("loop_stop_busy", busy, 0);
    loop_en = 1'b0;

    // Stop during entry 1
    clear_log();
    pulse_start(4'd3);
    wait_strobes(2, 100, "stop_timeout");
    repeat (3) @(negedge clk);
    pulse_stop();
    check("stop_busy", busy, 0);
    check("stop_freq", base_freq, 50000);
    check("stop_mode", sweep_mode, 2);
    check("stop_idx", step_idx, 1);
    repeat (40) @(negedge clk);
    check("stop_no_done", done_cnt, 0);
    check("stop_no_strobe", strobe_t.size(), 2);
    clear_log();
    pulse_start(4'd3);
    wait_strobes(1, 20, "restart_timeout");
    check("restart_idx", step_idx, 0);
    check("restart_freq", base_freq, 10000);

    // Rejected requests
    wr_addr  = 3'd0;
    wr_freq  = 20'd77777;
    wr_mode  = 2'b11;
    wr_dwell = 16'd9;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
    check("wr_busy_err", err, 1);
    check("wr_busy_state", busy, 1);
    @(negedge clk);
    check("wr_busy_err_pulse", err, 0);
    pulse_stop();
    pulse_start(4'd0);
    check("start0_err", err, 1);
    check("start0_busy", busy, 0);
    @(negedge clk);
    check("start0_err_pulse", err, 0);
    pulse_start(4'd9);
    check("start9_err", err, 1);
    check("start9_busy", busy, 0);
    @(negedge clk);
    check("err_total", err_cnt, 3);
    clear_log();
    pulse_start(4'd1);
    wait_idle(100, "mem_timeout");
    if (strobe_t.size() >= 1) begin
      check("mem_freq", strobe_f[0], 10000);
      check("mem_mode", strobe_m[0], 1);
      check("mem_dwell", done_t - strobe_t[0], 20);
    end

    // Zero dwell counts as 1 ms
    write_entry(3'd0, 20'd30000, 2'b01, 16'd0);
    clear_log();
    pulse_start(4'd1);
    wait_idle(100, "dw0_timeout");
    check("dw0_nstrobe", strobe_t.size(), 1);
    if (strobe_t.size() >= 1) begin
      check("dw0_len", done_t - strobe_t[0], 10);
      check("dw0_freq", strobe_f[0], 30000);
    end
    num_steps = 4'd3;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("ss_no_strobe", strobe_t.size(), 1);
    check("ss_no_err", err_cnt, 0);

    // Asynchronous reset mid-dwell
    write_entry(3'd0, 20'd10000, 2'b01, 16'd2);
    clear_log();
    pulse_start(4'd3);
    wait_strobes(1, 20, "ar_timeout");
    repeat (4) @(negedge clk);
    check("ar_pre_freq", base_freq, 10000);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("ar");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_busy_after", busy, 0);
    check("ar_no_done", done_cnt, 0);
    clear_log();
    pulse_start(4'd1);
    wait_idle(100, "ar_run_timeout");
    check("ar_nstrobe", strobe_t.size(), 1);
    if (strobe_t.size() >= 1) begin
      check("ar_mem_freq", strobe_f[0], 0);
      check("ar_mem_mode", strobe_m[0], 0);
      check("ar_mem_dwell", done_t - strobe_t[0], 10);
    end
    check("ar_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
